// File: rtl/udm_seq_mult.sv
// Iterative unsigned W x W multiplier built from 2x2 under-designed digit blocks.
// One 2-bit digit row of the multiplier is folded into the accumulator per cycle.
module udm_seq_mult #(
    parameter int W        = 8,
    parameter int LSB_ZONE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in1,
    input  logic [W-1:0]     in2,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   res,
    output logic             approx_hit
);

    localparam int ROWS  = W / 2;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r;
    logic [W-1:0]         a_r;
    logic [W-1:0]         b_r;
    logic [1:0]           mode_r;
    logic [ROW_W-1:0]     row_r;
    logic [2*W-1:0]       res_r;
    logic                 hit_r;
    logic                 in_ready_r;
    logic                 out_valid_r;

    logic [2*W-1:0]       row_term_s;
    logic [2*W-1:0]       part_s;
    logic                 row_hit_s;
    logic                 approx_s;
    logic [1:0]           digit_a_s;

    // The 3x3 case is the only entry of the 2x2 table that the approximate block gets wrong.
    function automatic logic [3:0] udm_2x2(input logic [1:0] a, input logic [1:0] b,
                                           input logic approx);
        if (approx && (a == 2'b11) && (b == 2'b11)) begin
            udm_2x2 = 4'd7;
        end else begin
            udm_2x2 = {2'b00, a} * {2'b00, b};
        end
    endfunction

    // Row term for the current multiplier digit (b_r is shifted so the digit is always in [1:0]).
    always_comb begin
        row_term_s = '0;
        row_hit_s  = 1'b0;
        part_s     = '0;
        approx_s   = 1'b0;
        digit_a_s  = 2'b00;
        for (int i = 0; i < ROWS; i++) begin
            digit_a_s = a_r[2*i +: 2];
            approx_s  = (mode_r == 2'd1) ||
                        ((mode_r == 2'd2) && ((i + int'(row_r)) < LSB_ZONE));
            if (approx_s && (digit_a_s == 2'b11) && (b_r[1:0] == 2'b11)) begin
                row_hit_s = 1'b1;
            end else begin
                row_hit_s = row_hit_s;
            end
            part_s      = '0;
            part_s[3:0] = udm_2x2(digit_a_s, b_r[1:0], approx_s);
            row_term_s  = row_term_s + (part_s << (2 * i));
        end
    end

    // Handshake FSM, operand capture and row accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            a_r         <= '0;
            b_r         <= '0;
            mode_r      <= 2'd0;
            row_r       <= '0;
            res_r       <= '0;
            hit_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r        <= in1;
                        b_r        <= in2;
                        mode_r     <= mode;
                        row_r      <= '0;
                        res_r      <= '0;
                        hit_r      <= 1'b0;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_CALC;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    res_r <= res_r + (row_term_s << {row_r, 1'b0});
                    hit_r <= hit_r | row_hit_s;
                    b_r   <= b_r >> 2;
                    if (row_r == ROW_LAST) begin
                        row_r       <= '0;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        row_r       <= row_r + ROW_W'(1);
                    end
                end
                ST_DONE: begin
                    // Results are held after the handshake; only the valid flag drops.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign res        = res_r;
    assign approx_hit = hit_r;

endmodule

// File: tb/tb_udm_seq_mult.sv
// Directed and pseudo-random checks of udm_seq_mult at W=8, LSB_ZONE=4.
module tb_udm_seq_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in1 = 8'h00;
    logic [7:0]  in2 = 8'h00;
    logic [1:0]  mode = 2'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] res;
    logic        approx_hit;

    int n_checks = 0;
    int n_pass   = 0;

    udm_seq_mult #(.W(8), .LSB_ZONE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .res(res), .approx_hit(approx_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  m;
        logic [15:0] r;
        logic        h;
    } vec_t;

    // Digit-sum reference: returns {hit, product}.
    function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] m);
        int s = 0;
        logic h = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                int ai = (a >> (2 * i)) & 3;
                int bj = (b >> (2 * j)) & 3;
                int p  = ai * bj;
                if ((m == 2'd1 || (m == 2'd2 && i + j < 4)) && ai == 3 && bj == 3) begin
                    p = 7;
                    h = 1'b1;
                end
                s = s + (p << (2 * (i + j)));
            end
        end
        return {h, s[15:0]};
    endfunction

    // Stimulus only: issue one transaction from a negedge with in_ready high.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                           input bit rand_ready, output logic [15:0] r, output logic h,
                           output int lat);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in1 = a; in2 = b; mode = m; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in1 = 8'($urandom); in2 = 8'($urandom); mode = 2'($urandom);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        r = res;
        h = approx_hit;
        if (lat > 0) begin
            for (int k = 0; k < 50; k++) begin
                out_ready = (rand_ready && k < 49) ? 1'($urandom_range(0, 1)) : 1'b1;
                @(posedge clk);
                @(negedge clk);
                if (out_ready) begin
                    out_ready = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] r;
        logic        h;
        int          lat;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, res, approx_hit} !== {1'b1, 1'b0, 16'h0000, 1'b0})
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h hit=%b want rdy=1 vld=0 res=0000 hit=0",
                     in_ready, out_valid, res, approx_hit);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        in1 = 8'hFF; in2 = 8'hFF; mode = 2'd0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, res} !== {1'b1, 1'b0, 16'h0000})
            $display("FAIL reset_mid_calc: got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=0000",
                     in_ready, out_valid, res);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) lat++;
        end
        n_checks++;
        if (lat !== 0) $display("FAIL reset_no_output: got %0d valid cycles want 0", lat);
        else n_pass++;
        run_txn(8'h05, 8'h07, 2'd0, 1'b0, r, h, lat);
        n_checks++;
        if (r !== 16'h0023) $display("FAIL reset_recover: got %h want 0023", r);
        else n_pass++;
    endtask

    task automatic test_modes();
        vec_t        v[8];
        logic [15:0] r;
        logic        h;
        int          lat;
        v[0] = '{8'hFF, 8'hFF, 2'd0, 16'hFE01, 1'b0};
        v[1] = '{8'hFF, 8'hFF, 2'd1, 16'hC58F, 1'b1};
        v[2] = '{8'h02, 8'h03, 2'd1, 16'h0006, 1'b0};
        v[3] = '{8'h03, 8'h03, 2'd2, 16'h0007, 1'b1};
        v[4] = '{8'hC0, 8'hC0, 2'd2, 16'h9000, 1'b0};
        v[5] = '{8'hC0, 8'h03, 2'd2, 16'h01C0, 1'b1};
        v[6] = '{8'hFF, 8'hFF, 2'd3, 16'hFE01, 1'b0};
        v[7] = '{8'hFF, 8'hFF, 2'd2, 16'hFB8F, 1'b1};
        for (int n = 0; n < 8; n++) begin
            run_txn(v[n].a, v[n].b, v[n].m, 1'b0, r, h, lat);
            n_checks++;
            if (lat !== 4 || r !== v[n].r || h !== v[n].h)
                $display("FAIL mode_vec%0d: got lat=%0d res=%h hit=%b want lat=4 res=%h hit=%b",
                         n, lat, r, h, v[n].r, v[n].h);
            else n_pass++;
        end
        n_checks++;
        if ({in_ready, out_valid, res} !== {1'b1, 1'b0, 16'hFB8F})
            $display("FAIL after_handshake: got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=fb8f",
                     in_ready, out_valid, res);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int          bad = 0;
        logic [15:0] r;
        logic        h;
        int          lat;
        @(negedge clk);
        in1 = 8'h0F; in2 = 8'h0E; mode = 2'd0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in1 = 8'h11; in2 = 8'h22;
        for (int k = 0; k < 4; k++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (res !== 16'h00D2 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL backpressure_hold: got %0d bad cycles want 0 (res=%h)", bad, res);
        else n_pass++;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL backpressure_release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL backpressure_reaccept: got rdy=%b want 0", in_ready);
        else n_pass++;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        n_checks++;
        if (lat !== 4 || res !== 16'h0242)
            $display("FAIL backpressure_second: got lat=%0d res=%h want lat=4 res=0242", lat, res);
        else n_pass++;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        r = 16'h0; h = 1'b0;
    endtask

    task automatic test_back_to_back();
        int          bad = 0;
        logic [15:0] r;
        logic        h;
        logic [16:0] exp;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  m;
        int          lat;
        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom);
            b = (n % 4 == 0) ? 8'hFF : 8'($urandom);
            m = 2'(n % 4);
            exp = model(a, b, m);
            run_txn(a, b, m, 1'b1, r, h, lat);
            if (lat !== 4 || {h, r} !== exp) begin
                bad++;
                $display("FAIL random_txn%0d: a=%h b=%h m=%0d got lat=%0d res=%h hit=%b want lat=4 res=%h hit=%b",
                         n, a, b, m, lat, r, h, exp[15:0], exp[16]);
            end
        end
        n_checks++;
        if (bad !== 0) $display("FAIL random_summary: got %0d bad want 0", bad);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
